// File: rtl/sine_block_sequencer.sv
// rtl/sine_block_sequencer.sv - stride-3 ROM address sequencer presenting registered sample blocks over valid/ready
module sine_block_sequencer #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_blocks,
    output logic [ADDR_WIDTH-1:0] r_addr,
    input  logic [DATA_WIDTH-1:0] r_data_1,
    input  logic [DATA_WIDTH-1:0] r_data_2,
    input  logic [DATA_WIDTH-1:0] r_data_3,
    output logic [DATA_WIDTH-1:0] x0,
    output logic [DATA_WIDTH-1:0] x1,
    output logic [DATA_WIDTH-1:0] x2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   blocks_sent
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    // Last usable block base: a block at this base still fits its three words in the table.
    localparam int                  LAST_BASE_I = 2 ** ADDR_WIDTH - 3;
    localparam logic [ADDR_WIDTH:0] LAST_BASE   = LAST_BASE_I[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] STRIDE      = {{(ADDR_WIDTH - 1){1'b0}}, 2'b11};
    localparam logic [ADDR_WIDTH:0] ONE         = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ADDR_WIDTH:0]     r_count;
    logic [ADDR_WIDTH:0]     r_issued;
    logic [ADDR_WIDTH:0]     w_addr_sum;
    logic [ADDR_WIDTH-1:0]   w_addr_next;
    logic [ADDR_WIDTH:0]     w_issued_inc;
    logic                    w_start_ok;
    logic                    w_load;
    logic                    w_accept;
    logic                    w_last_load;

    // Comparison done one bit wider so r_addr + 3 cannot overflow before the wrap test.
    assign w_addr_sum   = {1'b0, r_addr} + STRIDE;
    assign w_addr_next  = (w_addr_sum > LAST_BASE) ? '0 : w_addr_sum[ADDR_WIDTH-1:0];
    assign w_issued_inc = r_issued + ONE;
    assign w_start_ok   = (r_state == S_IDLE) && start;
    assign w_load       = (r_state == S_RUN) && (r_issued < r_count) && (!out_valid || out_ready);
    assign w_accept     = out_valid && out_ready;
    assign w_last_load  = w_load && (w_issued_inc == r_count);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and state-decoded status outputs.
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = (num_blocks != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last_load) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (w_accept) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Run bookkeeping, address stepping and the output block register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count     <= '0;
            r_issued    <= '0;
            r_addr      <= '0;
            x0          <= '0;
            x1          <= '0;
            x2          <= '0;
            out_valid   <= 1'b0;
            blocks_sent <= '0;
        end else begin
            if (w_start_ok) begin
                r_count     <= num_blocks;
                r_issued    <= '0;
                r_addr      <= '0;
                blocks_sent <= '0;
            end
            if (w_load) begin
                x0       <= r_data_1;
                x1       <= r_data_2;
                x2       <= r_data_3;
                r_issued <= w_issued_inc;
                r_addr   <= w_addr_next;
            end
            // A load keeps the slot full even when the previous block leaves on the same edge.
            if (w_load) begin
                out_valid <= 1'b1;
            end else if (w_accept) begin
                out_valid <= 1'b0;
            end
            if (w_accept) begin
                blocks_sent <= blocks_sent + ONE;
            end
        end
    end

endmodule

// File: tb/tb_sine_block_sequencer.sv
// tb/tb_sine_block_sequencer.sv - randomized self-checking bench for sine_block_sequencer
module tb_sine_block_sequencer;

    localparam int AW = 9;
    localparam int DW = 16;
    localparam int DEPTH = 2 ** AW;
    localparam int PERIOD_WORDS = ((DEPTH - 3) / 3 + 1) * 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic [AW:0]     num_blocks = '0;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_data_1, r_data_2, r_data_3;
    logic [DW-1:0]   x0, x1, x2;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            busy;
    logic            done;
    logic [AW:0]     blocks_sent;

    logic [DW-1:0]   rom [DEPTH];
    int              pass_cnt = 0;
    int              total_cnt = 0;

    always #5 clk = ~clk;

    assign r_data_1 = rom[int'(r_addr)];
    assign r_data_2 = rom[(int'(r_addr) + 1) % DEPTH];
    assign r_data_3 = rom[(int'(r_addr) + 2) % DEPTH];

    sine_block_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_blocks  (num_blocks),
        .r_addr      (r_addr),
        .r_data_1    (r_data_1),
        .r_data_2    (r_data_2),
        .r_data_3    (r_data_3),
        .x0          (x0),
        .x1          (x1),
        .x2          (x2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done),
        .blocks_sent (blocks_sent)
    );

    function automatic logic [3*DW-1:0] model_block(input int k);
        int base;
        base = (3 * k) % PERIOD_WORDS;
        return {rom[base], rom[base + 1], rom[base + 2]};
    endfunction

    task automatic test_reset();
        #3 rst = 1'b1;
        #1;
        total_cnt++;
        if ({r_addr, x0, x1, x2, blocks_sent, out_valid, busy, done} !== '0) begin
            $display("FAIL reset_async: got addr=%0d x=%h/%h/%h sent=%0d v=%b busy=%b done=%b, want all 0",
                     r_addr, x0, x1, x2, blocks_sent, out_valid, busy, done);
        end else pass_cnt++;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // mode 0: ready always high, 1: random ready, 2: ready pattern 1,0,0,1,1 then high
    task automatic run_and_check(input int n, input int mode, input bit poke_start, input string name);
        int accepted, last_acc_iter, done_iter, budget, first_valid;
        bit prev_valid, prev_ready, any_valid;
        logic [3*DW-1:0] prev_x;
        int pat [5] = '{1, 0, 0, 1, 1};
        accepted = 0; last_acc_iter = -1; done_iter = -1; first_valid = -1;
        prev_valid = 0; prev_ready = 0; any_valid = 0; prev_x = '0;
        budget = 4 * n + 40;
        num_blocks = n[AW:0];
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        total_cnt++;
        if ({busy, r_addr, blocks_sent} !== {(n != 0), {AW{1'b0}}, {(AW + 1){1'b0}}}) begin
            $display("FAIL %s start_edge: got busy=%b addr=%0d sent=%0d, want busy=%b addr=0 sent=0",
                     name, busy, r_addr, blocks_sent, n != 0);
        end else pass_cnt++;
        for (int it = 0; it < budget; it++) begin
            if (mode == 0) out_ready = 1'b1;
            else if (mode == 1) out_ready = ($urandom % 4) != 0;
            else out_ready = (it < 5) ? pat[it][0] : 1'b1;
            start = poke_start && (it == 3);
            @(negedge clk);
            if (prev_valid && !prev_ready) begin
                total_cnt++;
                if ({out_valid, x0, x1, x2} !== {1'b1, prev_x}) begin
                    $display("FAIL %s hold: got v=%b x=%h, want v=1 x=%h", name, out_valid, {x0, x1, x2}, prev_x);
                end else pass_cnt++;
            end
            if (out_valid) begin
                any_valid = 1;
                if (first_valid < 0) first_valid = it;
            end
            if (out_valid && out_ready) begin
                total_cnt++;
                if ({x0, x1, x2} !== model_block(accepted)) begin
                    $display("FAIL %s block%0d: got %h, want %h", name, accepted, {x0, x1, x2}, model_block(accepted));
                end else pass_cnt++;
                accepted++;
                last_acc_iter = it;
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_x = {x0, x1, x2};
            if (done) begin
                done_iter = it;
                break;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        total_cnt++;
        if (done_iter < 0) begin
            $display("FAIL %s timeout: no done within %0d cycles, want done", name, budget);
        end else if (done_iter != last_acc_iter + 1 || busy !== 1'b0) begin
            $display("FAIL %s done_timing: got done at %0d busy=%b, want %0d busy=0", name, done_iter, busy, last_acc_iter + 1);
        end else pass_cnt++;
        total_cnt++;
        if (accepted != n || blocks_sent !== n[AW:0] || any_valid != (n != 0)) begin
            $display("FAIL %s count: got accepts=%0d sent=%0d valid_seen=%0d, want %0d/%0d/%0d",
                     name, accepted, blocks_sent, any_valid, n, n, n != 0);
        end else pass_cnt++;
        if (n != 0) begin
            total_cnt++;
            if (first_valid != 1) begin
                $display("FAIL %s latency: got first valid at %0d, want 1", name, first_valid);
            end else pass_cnt++;
        end
        @(posedge clk);
        #1;
        total_cnt++;
        if ({done, busy, out_valid, blocks_sent} !== {3'b000, n[AW:0]}) begin
            $display("FAIL %s after_done: got done=%b busy=%b v=%b sent=%0d, want 0/0/0/%0d",
                     name, done, busy, out_valid, blocks_sent, n);
        end else pass_cnt++;
    endtask

    task automatic test_abort();
        int seen;
        seen = 0;
        num_blocks = 10;
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int it = 0; it < 20; it++) begin
            @(negedge clk);
            if (blocks_sent == 2) begin
                seen = 1;
                break;
            end
        end
        total_cnt++;
        if (seen == 0) begin
            $display("FAIL abort_reach: got sent=%0d, want 2 accepts before reset", blocks_sent);
        end else pass_cnt++;
        #1 rst = 1'b1;
        #1;
        total_cnt++;
        if ({r_addr, x0, x1, x2, blocks_sent, out_valid, busy, done} !== '0) begin
            $display("FAIL abort_reset: got addr=%0d x=%h/%h/%h sent=%0d v=%b busy=%b done=%b, want all 0",
                     r_addr, x0, x1, x2, blocks_sent, out_valid, busy, done);
        end else pass_cnt++;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) rom[i] = DW'($urandom);
        test_reset();
        run_and_check(4, 0, 1'b0, "basic");
        run_and_check(3, 2, 1'b0, "backpressure");
        run_and_check(172, 0, 1'b0, "wrap");
        run_and_check(0, 0, 1'b0, "zero_len");
        run_and_check(25, 1, 1'b0, "random_ready");
        test_abort();
        run_and_check(8, 1, 1'b1, "rearm_ignore_start");
        run_and_check(1, 0, 1'b0, "single");
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sine_block_sequencer.md
# sine_block_sequencer

Upstream stimulus stage for the L=3 reduced-parallel FIR bench. It owns the sample ROM's read address and steps it in strides of three. It captures the three parallel samples the ROM returns combinationally and presents them to the filter as one registered block behind a valid/ready handshake. A run is a programmed number of blocks, with wrap-around at the end of the table and a one-cycle completion pulse.

## Interface
- ADDR_WIDTH, 9, ROM address width; table depth 2**ADDR_WIDTH.
- DATA_WIDTH, 16, sample width.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begins a run; sampled only in IDLE.
- num_blocks  in  ADDR_WIDTH+1  blocks to issue; latched on accepted start.
- r_addr  out  ADDR_WIDTH  ROM read address (block base); registered.
- r_data_1, r_data_2, r_data_3  in  DATA_WIDTH each  ROM words at r_addr, r_addr+1, r_addr+2 (combinational).
- x0, x1, x2  out  DATA_WIDTH each  registered block: x0 = sample n, x1 = n+1, x2 = n+2.
- out_valid  out  1  block on x0..x2 is valid.
- out_ready  in  1  consumer accepts the block this cycle.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse at end of run.
- blocks_sent  out  ADDR_WIDTH+1  count of accepted blocks in current/last run.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN when start=1 and latched num_blocks != 0.
  - Same edge: r_addr <= 0, issued <= 0, blocks_sent <= 0.
- IDLE -> DONE when start=1 and num_blocks == 0; no block is ever issued.
- start is ignored outside IDLE.
- Load condition: state RUN and issued < latched count and (out_valid == 0 or out_ready == 1). On load:
  - x0..x2 <= r_data_1..3;
  - out_valid <= 1;
  - issued increments;
  - r_addr advances.
- Address advance: next = 0 if r_addr + 3 > 2**ADDR_WIDTH − 3, else r_addr + 3. Compute the comparison at ADDR_WIDTH+1 bits.
  - With ADDR_WIDTH=9, block bases are 0, 3, …, 507, then 0.
  - Words 510–511 are never used. A period is 170 blocks.
- Accept: out_valid && out_ready at an edge increments blocks_sent.
  - If no load occurs on the same edge, out_valid <= 0.
  - Load and accept on the same edge keeps out_valid high, giving one block per cycle.
- x0..x2 hold their value whenever out_valid=1 and out_ready=0.
- RUN -> DRAIN on the edge that performs the final load.
- DRAIN -> DONE on the edge where the final block is accepted.
- DONE: done=1 for exactly one cycle, then IDLE. blocks_sent holds until the next accepted start.
- Reset (any time, including mid-run):
  - state IDLE;
  - r_addr, x0..x2, blocks_sent, issued = 0;
  - out_valid, busy, done = 0.
  - The partial run is discarded.

## Timing
- Start accepted at edge E:
  - r_addr = 0 from E;
  - first block captured at E+1, so out_valid is high in the cycle after E+1;
  - start-to-valid latency is 2 edges.
- With out_ready held high, N blocks are accepted on consecutive edges E+2 … E+N+1.
- done is high in the cycle after the last accept.
- busy = 1 from E through the final accept edge, and 0 in DONE.
- r_addr changes only on load edges. ROM data is sampled at the same edge that r_addr advances, which requires a combinational ROM path.
- Backpressure: when out_ready is low, no load and no address change occur. out_valid never drops without an accept.

## Test plan
- Reset: assert rst mid-cycle with no clock -> all outputs 0 immediately; state IDLE; done=0.
- Basic run: num_blocks=4, out_ready=1, pulse start -> 4 consecutive valid blocks from bases 0, 3, 6, 9 (x0 = sine[0], sine[3], sine[6], sine[9]); done one cycle after the 4th accept; blocks_sent=4.
- Backpressure: num_blocks=3, out_ready toggling 1,0,0,1,1 -> x0..x2 stable while stalled; exactly 3 accepts, in order 0, 3, 6; no duplicates or drops.
- Wrap: num_blocks=172, out_ready=1 -> block 170 base 507 (words 507–509); block 171 base 0; block 172 base 3; done after 172 accepts.
- Zero length: num_blocks=0, start -> done pulse 1 cycle after start; out_valid never asserts; blocks_sent=0.
- Abort and re-arm: reset after 2 accepts of a 10-block run -> outputs cleared. start during a subsequent busy run is ignored. A fresh start restarts at base 0.
